// File: rtl/paddle_dec_pkg.sv
// Shared types and constants for the paddle pulse decoder.
// Optional feature macro: PADDLE_DEC_FILTER_EN (4-capture moving-average on pos).
package paddle_dec_pkg;

    // Decoder control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } dec_state_t;

    // Default saturation / timeout line count.
    localparam int unsigned PAD_DEFAULT_MAX = 255;

    // Number of captures averaged by the position filter (power of two).
    localparam int unsigned FILT_DEPTH = 4;

    // True for states in which a measurement is in progress.
    function automatic logic is_busy_state(input dec_state_t s);
        return (s == ARM) || (s == MEASURE);
    endfunction

endpackage : paddle_dec_pkg

// File: rtl/paddle_pos_filter.sv
// Moving-average filter over the last FILT_DEPTH raw position captures.
// Instantiated by paddle_pulse_decoder only when PADDLE_DEC_FILTER_EN is defined.
// The first capture after reset preloads every history entry; output is the
// truncating mean, registered one cycle after the input strobe.
module paddle_pos_filter
    import paddle_dec_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    input  logic [CNT_W-1:0] in_pos_i,
    output logic [CNT_W-1:0] pos_o,
    output logic             pos_valid_o
);

    localparam int unsigned SHIFT = $clog2(FILT_DEPTH);
    localparam int unsigned SUM_W = CNT_W + SHIFT;

    logic [CNT_W-1:0] hist_q [FILT_DEPTH];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_d;
    logic             primed_q;
    logic [CNT_W-1:0] pos_q;
    logic             pos_valid_q;

    // Running sum of the history: add the newcomer, drop the oldest entry.
    // Before the first capture the sum is the newcomer replicated FILT_DEPTH times.
    always_comb begin
        sum_d = sum_q;
        if (primed_q) begin
            sum_d = sum_q + SUM_W'(in_pos_i) - SUM_W'(hist_q[FILT_DEPTH-1]);
        end else begin
            sum_d = SUM_W'(in_pos_i) << SHIFT;
        end
    end

    // History shift, sum register and registered mean output.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < FILT_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            sum_q       <= '0;
            primed_q    <= 1'b0;
            pos_q       <= '0;
            pos_valid_q <= 1'b0;
        end else begin
            pos_valid_q <= in_valid_i;
            if (in_valid_i) begin
                hist_q[0] <= in_pos_i;
                for (int unsigned i = 1; i < FILT_DEPTH; i++) begin
                    hist_q[i] <= primed_q ? hist_q[i-1] : in_pos_i;
                end
                sum_q    <= sum_d;
                primed_q <= 1'b1;
                pos_q    <= sum_d[SUM_W-1:SHIFT];
            end
        end
    end

    assign pos_o       = pos_q;
    assign pos_valid_o = pos_valid_q;

endmodule : paddle_pos_filter

// File: rtl/paddle_pulse_decoder.sv
// Paddle pot-timing decoder: counts hsync rising edges while pad_out is high
// after a pad_en_n trigger release, and publishes the count with a strobe.
// Optional macro PADDLE_DEC_FILTER_EN routes captures through paddle_pos_filter
// (4-capture mean, strobe one cycle later); default build publishes raw captures.
module paddle_pulse_decoder
    import paddle_dec_pkg::*;
#(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_LINES = PAD_DEFAULT_MAX
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             pad_en_n,
    input  logic             pad_out,
    input  logic             hsync,
    output logic [CNT_W-1:0] pos,
    output logic             pos_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] SAT_VAL = CNT_W'(MAX_LINES);
    localparam logic [CNT_W-1:0] PRE_SAT = CNT_W'(MAX_LINES - 1);

    dec_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cap_q;
    logic             tflag_q;
    logic [CNT_W-1:0] raw_pos_q;
    logic             raw_valid_q;
    logic             timeout_q;
    logic             busy_q;

    logic             hsync_q;
    logic             pad_en_q;
    logic             hs_edge;
    logic             en_rise;

    // Previous-cycle copies of hsync and pad_en_n for edge detection.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q  <= 1'b0;
            pad_en_q <= 1'b1;
        end else begin
            hsync_q  <= hsync;
            pad_en_q <= pad_en_n;
        end
    end

    assign hs_edge = hsync & ~hsync_q;
    assign en_rise = pad_en_n & ~pad_en_q;

    // Measurement FSM with registered capture, strobe, timeout and busy.
    // Saturation is detected one count early so cnt_q never wraps.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cap_q       <= '0;
            tflag_q     <= 1'b0;
            raw_pos_q   <= '0;
            raw_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            raw_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!pad_en_n) begin
                        state_q <= ARM;
                        busy_q  <= is_busy_state(ARM);
                    end
                end
                ARM: begin
                    cnt_q   <= '0;
                    tflag_q <= 1'b0;
                    if (en_rise) begin
                        state_q <= MEASURE;
                        busy_q  <= is_busy_state(MEASURE);
                    end
                end
                MEASURE: begin
                    if (!pad_en_n) begin
                        state_q <= ARM;
                        busy_q  <= is_busy_state(ARM);
                    end else if (!pad_out) begin
                        cap_q   <= cnt_q;
                        tflag_q <= 1'b0;
                        state_q <= DONE;
                        busy_q  <= is_busy_state(DONE);
                    end else if (hs_edge) begin
                        if (cnt_q == PRE_SAT) begin
                            cnt_q   <= SAT_VAL;
                            cap_q   <= SAT_VAL;
                            tflag_q <= 1'b1;
                            state_q <= DONE;
                            busy_q  <= is_busy_state(DONE);
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    raw_pos_q   <= cap_q;
                    raw_valid_q <= 1'b1;
                    timeout_q   <= tflag_q;
                    state_q     <= IDLE;
                    busy_q      <= is_busy_state(IDLE);
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PADDLE_DEC_FILTER_EN
    logic [CNT_W-1:0] filt_pos;
    logic             filt_valid;

    paddle_pos_filter #(
        .CNT_W (CNT_W)
    ) u_pos_filter (
        .clk_i       (clk_sys),
        .rst_n_i     (reset_n),
        .in_valid_i  (raw_valid_q),
        .in_pos_i    (raw_pos_q),
        .pos_o       (filt_pos),
        .pos_valid_o (filt_valid)
    );

    assign pos       = filt_pos;
    assign pos_valid = filt_valid;
`else
    assign pos       = raw_pos_q;
    assign pos_valid = raw_valid_q;
`endif

    assign timeout = timeout_q;
    assign busy    = busy_q;

endmodule : paddle_pulse_decoder

// File: tb/tb_paddle_pulse_decoder.sv
// Directed self-checking bench for paddle_pulse_decoder.
// Default build checks raw decoding; with PADDLE_DEC_FILTER_EN it checks the
// averaged output instead.
module tb_paddle_pulse_decoder;

`ifdef PADDLE_DEC_FILTER_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk_sys;
    logic       reset_n;
    logic       pad_en_n;
    logic       pad_out;
    logic       hsync;
    logic [7:0] pos;
    logic       pos_valid;
    logic       timeout;
    logic       busy;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    paddle_pulse_decoder #(
        .CNT_W     (8),
        .MAX_LINES (255)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .pad_en_n  (pad_en_n),
        .pad_out   (pad_out),
        .hsync     (hsync),
        .pos       (pos),
        .pos_valid (pos_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Count every strobe seen, for frame-count checks.
    always @(negedge clk_sys) begin
        if (pos_valid) strobes++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic hs_pulse();
        hsync = 1'b1;
        tick();
        hsync = 1'b0;
        tick();
    endtask

    // One paddle frame as the emu one-shot generator would produce it.
    task automatic run_frame(input int lines, input logic [7:0] exp_pos,
                             input logic exp_to, input bit same_edge, input string tag);
        int s0;
        s0 = strobes;
        pad_en_n = 1'b0;
        pad_out  = 1'b0;
        repeat (10) tick();
        check_eq({tag, "_busy_arm"}, 32'(busy), 32'd1);
        pad_en_n = 1'b1;
        pad_out  = 1'b1;
        tick();
        repeat (lines) hs_pulse();
        pad_out = 1'b0;
        if (same_edge) hsync = 1'b1;
        for (int c = 1; c < LAT; c++) begin
            tick();
            hsync = 1'b0;
            check_eq({tag, "_early_valid"}, 32'(pos_valid), 32'd0);
        end
        tick();
        hsync = 1'b0;
        check_eq({tag, "_valid"}, 32'(pos_valid), 32'd1);
        check_eq({tag, "_pos"}, 32'(pos), 32'(exp_pos));
        check_eq({tag, "_timeout"}, 32'(timeout), 32'(exp_to));
        tick();
        check_eq({tag, "_valid_drop"}, 32'(pos_valid), 32'd0);
        check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
        tick();
        check_eq({tag, "_strobes"}, 32'(strobes - s0), 32'd1);
    endtask

    initial begin
        int s0;
        reset_n  = 1'b0;
        pad_en_n = 1'b1;
        pad_out  = 1'b0;
        hsync    = 1'b0;
        repeat (3) tick();
        check_eq("rst_pos", 32'(pos), 32'd0);
        check_eq("rst_valid", 32'(pos_valid), 32'd0);
        check_eq("rst_timeout", 32'(timeout), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

`ifdef PADDLE_DEC_FILTER_EN
        run_frame(100, 8'd100, 1'b0, 1'b0, "f1");
        run_frame(100, 8'd100, 1'b0, 1'b0, "f2");
        run_frame(100, 8'd100, 1'b0, 1'b0, "f3");
        run_frame(104, 8'd101, 1'b0, 1'b0, "f4");
`else
        run_frame(114, 8'd114, 1'b0, 1'b0, "l114");
        run_frame(37,  8'd37,  1'b0, 1'b0, "loop37");
        run_frame(200, 8'd200, 1'b0, 1'b0, "loop200");
        run_frame(254, 8'd254, 1'b0, 1'b0, "l254");

        // 300 lines: saturates at 255 mid-train, later edges ignored in IDLE.
        s0 = strobes;
        pad_en_n = 1'b0;
        repeat (10) tick();
        pad_en_n = 1'b1;
        pad_out  = 1'b1;
        tick();
        repeat (300) hs_pulse();
        pad_out = 1'b0;
        repeat (3) tick();
        check_eq("sat_pos", 32'(pos), 32'd255);
        check_eq("sat_timeout", 32'(timeout), 32'd1);
        check_eq("sat_strobes", 32'(strobes - s0), 32'd1);
        check_eq("sat_busy", 32'(busy), 32'd0);

        run_frame(50, 8'd50, 1'b0, 1'b0, "l50");

        // Abort after 20 counted lines: no strobe, pos held.
        s0 = strobes;
        pad_en_n = 1'b0;
        repeat (4) tick();
        pad_en_n = 1'b1;
        pad_out  = 1'b1;
        tick();
        repeat (20) hs_pulse();
        pad_en_n = 1'b0;
        pad_out  = 1'b0;
        repeat (4) tick();
        check_eq("abort_pos", 32'(pos), 32'd50);
        check_eq("abort_busy", 32'(busy), 32'd1);
        check_eq("abort_strobes", 32'(strobes - s0), 32'd0);
        run_frame(60, 8'd60, 1'b0, 1'b0, "l60");

        // Edge coinciding with pad_out fall is not counted; 0-line pulse.
        run_frame(5, 8'd5, 1'b0, 1'b1, "same_edge");
        run_frame(0, 8'd0, 1'b0, 1'b0, "zero");
        run_frame(9, 8'd9, 1'b0, 1'b0, "l9");

        // Asynchronous reset at line 80 of a measurement.
        s0 = strobes;
        pad_en_n = 1'b0;
        repeat (10) tick();
        pad_en_n = 1'b1;
        pad_out  = 1'b1;
        tick();
        repeat (80) hs_pulse();
        check_eq("midrst_busy_pre", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_pos", 32'(pos), 32'd0);
        check_eq("midrst_valid", 32'(pos_valid), 32'd0);
        check_eq("midrst_timeout", 32'(timeout), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        tick();
        pad_out = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check_eq("postrst_busy", 32'(busy), 32'd0);
        check_eq("postrst_strobes", 32'(strobes - s0), 32'd0);
        run_frame(3, 8'd3, 1'b0, 1'b0, "l3");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_paddle_pulse_decoder
